// File: rtl/dmem_mmio_pkg.sv
// Shared constants and helpers for the data-memory / MMIO responder.
package dmem_pkg;

  localparam logic [3:0] OFF_CYCLE  = 4'h0;
  localparam logic [3:0] OFF_LED    = 4'h4;
  localparam logic [3:0] OFF_TCMP   = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int ST_TIMER_HIT = 0;
  localparam int ST_MISALIGN  = 1;

  typedef enum logic {ACC_RAM, ACC_MMIO} access_kind_t;

  function automatic logic [7:0] get_lane(input logic [31:0] word, input logic [1:0] sel);
    return word[8*sel +: 8];
  endfunction

endpackage

// File: rtl/dmem_mmio_timer.sv
// Free-running cycle counter, timer compare register and sticky timer_hit flag.
module mmio_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tcmp_we,
  input  logic [31:0] tcmp_wdata,
  input  logic        hit_clr,
  output logic [31:0] cycle,
  output logic        timer_hit
);

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        hit_q, hit_d;
  logic        hit_set;

  always_comb begin
    cycle_d = cycle_q + 32'd1;
    tcmp_d  = tcmp_we ? tcmp_wdata : tcmp_q;
    // compare against the registered TCMP so a fresh write only matters next cycle
    hit_set = (tcmp_q != 32'd0) && (cycle_q == tcmp_q);
    hit_d   = hit_set | (hit_q & ~hit_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= 32'd0;
      tcmp_q  <= 32'd0;
      hit_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      tcmp_q  <= tcmp_d;
      hit_q   <= hit_d;
    end
  end

  assign cycle     = cycle_q;
  assign timer_hit = hit_q;

endmodule

// File: rtl/dmem_mmio.sv
// Data-side RAM with byte-lane stores plus a 4-register MMIO window.
module dmem_mmio
  import dmem_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_FF00,
  parameter int          LED_W     = 8,
  parameter              INIT_FILE = "memfile_data.dat"
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      writedata,
  input  logic             memwrite,
  input  logic             byte_enable,
  output logic [31:0]      readdata,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem_q [DEPTH];

  access_kind_t    kind;
  logic [AW-1:0]   idx;
  logic            misaligned;
  logic            ram_we;
  logic            mmio_we;
  logic [3:0]      lane_we;
  logic [31:0]     lane_data;
  logic            tcmp_we;
  logic            hit_clr;
  logic            mis_clr;
  logic [LED_W-1:0] led_q, led_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     cycle;
  logic            timer_hit;
  logic [31:0]     mmio_word;
  logic [31:0]     rd_word;

  always_comb begin
    kind       = (addr[31:4] == MMIO_BASE[31:4]) ? ACC_MMIO : ACC_RAM;
    idx        = addr[AW+1:2];
    misaligned = !byte_enable && (addr[1:0] != 2'b00);
    // reset drops any coincident store
    ram_we     = memwrite && !misaligned && (kind == ACC_RAM) && !reset;
    mmio_we    = memwrite && !byte_enable && !misaligned && (kind == ACC_MMIO);
    lane_we    = byte_enable ? (4'b0001 << addr[1:0]) : 4'b1111;
    lane_data  = byte_enable ? {4{writedata[7:0]}} : writedata;
    tcmp_we    = mmio_we && (addr[3:0] == OFF_TCMP);
    hit_clr    = mmio_we && (addr[3:0] == OFF_STATUS) && writedata[ST_TIMER_HIT];
    mis_clr    = mmio_we && (addr[3:0] == OFF_STATUS) && writedata[ST_MISALIGN];
    led_d      = (mmio_we && (addr[3:0] == OFF_LED)) ? writedata[LED_W-1:0] : led_q;
    misalign_d = (memwrite && misaligned) | (misalign_q & ~mis_clr);
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (ram_we && lane_we[l]) mem_q[idx][8*l +: 8] <= lane_data[8*l +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      led_q      <= led_d;
      misalign_q <= misalign_d;
    end
  end

  mmio_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .tcmp_we    (tcmp_we),
    .tcmp_wdata (writedata),
    .hit_clr    (hit_clr),
    .cycle      (cycle),
    .timer_hit  (timer_hit)
  );

  logic [31:0] tcmp_rd;
  assign tcmp_rd = u_timer.tcmp_q;

  always_comb begin
    mmio_word = 32'd0;
    case (addr[3:2])
      OFF_CYCLE[3:2]:  mmio_word = cycle;
      OFF_LED[3:2]:    mmio_word = 32'(led_q);
      OFF_TCMP[3:2]:   mmio_word = tcmp_rd;
      OFF_STATUS[3:2]: mmio_word = {30'd0, misalign_q, timer_hit};
      default:         mmio_word = 32'd0;
    endcase
    rd_word  = (kind == ACC_MMIO) ? mmio_word : mem_q[idx];
    readdata = byte_enable ? {24'd0, get_lane(rd_word, addr[1:0])} : rd_word;
  end

  assign led = led_q;
  assign irq = timer_hit;

endmodule
